// File: rtl/fft8_output_reorder_pkg.sv
// Shared constants and index helpers for the 8-point FFT pipeline.
// Imported by the output reorder buffer and its storage banks.
package fft8_output_reorder_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;
    localparam int SAMPLE_W  = 16;

    typedef logic [FFT_LOG2N-1:0] idx_t;

    function automatic idx_t bitrev3(input idx_t i);
        return {i[0], i[1], i[2]};
    endfunction

endpackage

// File: rtl/fft8_output_reorder_bank.sv
// One ping-pong half: 8-entry register file, synchronous write,
// asynchronous read. Contents are deliberately not reset.
module fft8_output_reorder_bank
    import fft8_output_reorder_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_we,
    input  idx_t         i_waddr,
    input  logic [W-1:0] i_wdata,
    input  idx_t         i_raddr,
    output logic [W-1:0] o_rdata
);

    logic [W-1:0] r_mem [FFT_N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft8_output_reorder.sv
// Captures bit-reversed FFT output frames into a ping-pong buffer
// and replays them in natural order over valid/ready.
module fft8_output_reorder
    import fft8_output_reorder_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_first,
    output logic              out_last,
    output logic              overflow,
    output logic              sync_err
);

    localparam int SW = 2 * DATA_W;

    logic [1:0] r_full;
    logic       r_wb;
    logic       r_rb;
    idx_t       r_wc;
    idx_t       r_rc;
    logic       r_ovf;
    logic       r_serr;

    logic          w_wfull;
    logic          w_acc;
    logic          w_resync;
    idx_t          w_widx;
    logic          w_wdone;
    logic          w_rd;
    logic          w_rdone;
    logic [1:0]    w_full_nxt;
    logic [SW-1:0] w_rdata [2];
    logic [SW-1:0] w_sel;

    assign w_wfull  = r_full[r_wb];
    assign w_acc    = in_valid & ~w_wfull;
    // in_first mid-frame restarts the frame at arrival index 0
    assign w_resync = in_valid & in_first & (r_wc != '0);
    assign w_widx   = w_resync ? '0 : r_wc;
    assign w_wdone  = w_acc & (w_widx == idx_t'(FFT_N - 1));
    assign w_rd     = r_full[r_rb] & out_ready;
    assign w_rdone  = w_rd & (r_rc == idx_t'(FFT_N - 1));

    generate
        for (genvar g = 0; g < 2; g++) begin : g_bank
            fft8_output_reorder_bank #(
                .W (SW)
            ) u_bank (
                .clk     (clk),
                .i_we    (w_acc & (r_wb == 1'(g))),
                .i_waddr (bitrev3(w_widx)),
                .i_wdata ({in_re, in_im}),
                .i_raddr (r_rc),
                .o_rdata (w_rdata[g])
            );
        end
    endgenerate

    // Set and clear always hit distinct banks
    always_comb begin
        w_full_nxt = r_full;
        if (w_wdone) w_full_nxt[r_wb] = 1'b1;
        if (w_rdone) w_full_nxt[r_rb] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= '0;
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_wc   <= '0;
            r_rc   <= '0;
            r_ovf  <= 1'b0;
            r_serr <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_acc) begin
                r_wc <= w_wdone ? '0 : w_widx + idx_t'(1);
                if (w_wdone) r_wb <= ~r_wb;
                if (w_resync) r_serr <= 1'b1;
            end
            if (in_valid & w_wfull) r_ovf <= 1'b1;
            if (w_rd) begin
                r_rc <= r_rc + idx_t'(1);
                if (w_rdone) r_rb <= ~r_rb;
            end
        end
    end

    assign w_sel     = w_rdata[r_rb];
    assign in_ready  = ~w_wfull;
    assign out_valid = r_full[r_rb];
    assign out_re    = out_valid ? w_sel[SW-1:DATA_W] : '0;
    assign out_im    = out_valid ? w_sel[DATA_W-1:0] : '0;
    assign out_first = out_valid & (r_rc == '0);
    assign out_last  = out_valid & (r_rc == idx_t'(FFT_N - 1));
    assign overflow  = r_ovf;
    assign sync_err  = r_serr;

endmodule

// File: tb/tb_fft8_output_reorder.sv
// Randomized bench for the FFT output reorder buffer against a
// frame-level natural-order queue model.
module tb_fft8_output_reorder;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        first;
        logic        last;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        out_first;
    logic        out_last;
    logic        overflow;
    logic        sync_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    int          nr_cnt;
    int          obs_base;
    bit          rand_ready = 0;
    logic [15:0] fr_re [8];
    logic [15:0] fr_im [8];
    logic [31:0] exp_q [$];
    obs_t        obs_q [$];
    int          obs_cyc [$];

    fft8_output_reorder #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_first (out_first),
        .out_last  (out_last),
        .overflow  (overflow),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        obs_t o;
        if (rst_n && out_valid && out_ready) begin
            o.re = out_re;
            o.im = out_im;
            o.first = out_first;
            o.last = out_last;
            obs_q.push_back(o);
            obs_cyc.push_back(cyc_cnt);
        end
    end

    // Arrival slot k carries natural-order sample with k's bits mirrored
    function automatic int arr_to_nat(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    function automatic obs_t get_obs(input int i);
        obs_t r = 'x;
        if (obs_base + i < obs_q.size()) r = obs_q[obs_base + i];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom % 2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        out_ready = 1'b0;
        rand_ready = 0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        exp_q.delete();
        obs_base = obs_q.size();
        nr_cnt = 0;
    endtask

    task automatic make_frame();
        for (int n = 0; n < 8; n++) begin
            fr_re[n] = 16'($urandom);
            fr_im[n] = 16'($urandom);
        end
    endtask

    task automatic send_frame(input bit with_first, input bit push,
                              input int nsamp);
        for (int k = 0; k < nsamp; k++) begin
            int n = arr_to_nat(k);
            in_valid = 1'b1;
            in_first = with_first && (k == 0);
            in_re = fr_re[n];
            in_im = fr_im[n];
            if (!in_ready) nr_cnt++;
            cyc();
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        if (push)
            for (int n = 0; n < 8; n++) exp_q.push_back({fr_re[n], fr_im[n]});
    endtask

    task automatic wait_obs(input string nm, input int n, input int budget);
        int c = 0;
        while (obs_q.size() - obs_base < n && c < budget) begin
            cyc();
            c++;
        end
        n_checks++;
        if (obs_q.size() - obs_base < n) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d samples, want %0d", nm,
                     obs_q.size() - obs_base, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, in_ready, overflow, sync_err, out_first, out_last,
             out_re, out_im} !== {6'b010000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset: got v=%b rdy=%b ovf=%b se=%b re=%h want 0/1/0/0/0",
                     out_valid, in_ready, overflow, sync_err, out_re);
        end
        do_reset();
    endtask

    task automatic test_single_frame();
        obs_t o;
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            fr_re[n] = 16'(n);
            fr_im[n] = 16'(n + 100);
        end
        send_frame(1, 1, 8);
        n_checks++;
        if (out_valid !== 1'b1 || out_first !== 1'b1 || out_re !== 16'd0
            || obs_q.size() != obs_base) begin
            n_fail++;
            $display("FAIL latency: got v=%b f=%b re=%h early=%0d want 1/1/0/0",
                     out_valid, out_first, out_re, obs_q.size() - obs_base);
        end
        wait_obs("single", 8, 20);
        for (int i = 0; i < exp_q.size(); i++) begin
            o = get_obs(i);
            n_checks++;
            if ({o.re, o.im} !== exp_q[i] || o.first !== 1'(i % 8 == 0)
                || o.last !== 1'(i % 8 == 7)) begin
                n_fail++;
                $display("FAIL single[%0d]: got %h/%h f%b l%b want %h", i,
                         o.re, o.im, o.first, o.last, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            make_frame();
            send_frame(1, 1, 8);
        end
        wait_obs("b2b", 32, 60);
        for (int i = 0; i < exp_q.size(); i++) begin
            o = get_obs(i);
            n_checks++;
            if ({o.re, o.im} !== exp_q[i] || o.first !== 1'(i % 8 == 0)
                || o.last !== 1'(i % 8 == 7)) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h/%h f%b l%b want %h", i,
                         o.re, o.im, o.first, o.last, exp_q[i]);
            end
        end
        n_checks++;
        if (obs_q.size() - obs_base < 32 ||
            obs_cyc[obs_base + 31] - obs_cyc[obs_base] != 31 ||
            nr_cnt != 0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stream: got n=%0d notready=%0d ovf=%b want contiguous 32/0/0",
                     obs_q.size() - obs_base, nr_cnt, overflow);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            make_frame();
            send_frame(1, 1, 8);
        end
        n_checks++;
        if (in_ready !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: got rdy=%b ovf=%b v=%b want 0/0/1",
                     in_ready, overflow, out_valid);
        end
        make_frame();
        send_frame(1, 0, 1);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ovf: got %b want 1", overflow);
        end
        out_ready = 1'b1;
        wait_obs("bp", 16, 40);
        repeat (4) cyc();
        for (int i = 0; i < exp_q.size(); i++) begin
            o = get_obs(i);
            n_checks++;
            if ({o.re, o.im} !== exp_q[i] || o.first !== 1'(i % 8 == 0)
                || o.last !== 1'(i % 8 == 7)) begin
                n_fail++;
                $display("FAIL bp[%0d]: got %h/%h f%b l%b want %h", i,
                         o.re, o.im, o.first, o.last, exp_q[i]);
            end
        end
        n_checks++;
        if (obs_q.size() - obs_base != 16 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: got n=%0d rdy=%b want 16/1",
                     obs_q.size() - obs_base, in_ready);
        end
    endtask

    task automatic test_resync();
        obs_t o;
        do_reset();
        out_ready = 1'b1;
        make_frame();
        send_frame(1, 0, 3);
        n_checks++;
        if (sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL resync_pre: got %b want 0", sync_err);
        end
        make_frame();
        fr_re[0] = 16'd0;
        send_frame(1, 1, 8);
        wait_obs("resync", 8, 20);
        repeat (12) cyc();
        n_checks++;
        if (sync_err !== 1'b1 || overflow !== 1'b0 ||
            obs_q.size() - obs_base != 8) begin
            n_fail++;
            $display("FAIL resync_flags: got se=%b ovf=%b n=%0d want 1/0/8",
                     sync_err, overflow, obs_q.size() - obs_base);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            o = get_obs(i);
            n_checks++;
            if ({o.re, o.im} !== exp_q[i] || o.first !== 1'(i % 8 == 0)
                || o.last !== 1'(i % 8 == 7)) begin
                n_fail++;
                $display("FAIL resync[%0d]: got %h/%h f%b l%b want %h", i,
                         o.re, o.im, o.first, o.last, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        obs_t o;
        do_reset();
        out_ready = 1'b1;
        make_frame();
        send_frame(1, 0, 5);
        rst_n = 1'b0;
        repeat (2) cyc();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst: got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        rst_n = 1'b1;
        cyc();
        obs_base = obs_q.size();
        make_frame();
        send_frame(0, 1, 8);
        wait_obs("midrst", 8, 20);
        repeat (12) cyc();
        n_checks++;
        if (sync_err !== 1'b0 || overflow !== 1'b0 ||
            obs_q.size() - obs_base != 8) begin
            n_fail++;
            $display("FAIL midrst_flags: got se=%b ovf=%b n=%0d want 0/0/8",
                     sync_err, overflow, obs_q.size() - obs_base);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            o = get_obs(i);
            n_checks++;
            if ({o.re, o.im} !== exp_q[i] || o.first !== 1'(i % 8 == 0)
                || o.last !== 1'(i % 8 == 7)) begin
                n_fail++;
                $display("FAIL midrst[%0d]: got %h/%h f%b l%b want %h", i,
                         o.re, o.im, o.first, o.last, exp_q[i]);
            end
        end
    endtask

    task automatic test_random_ready();
        obs_t o;
        do_reset();
        rand_ready = 1;
        for (int f = 0; f < 20; f++) begin
            int c = 0;
            while (!in_ready && c < 100) begin
                cyc();
                c++;
            end
            if (!in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_wait: got in_ready=0 want 1 within 100");
            end
            repeat ($urandom_range(0, 2)) cyc();
            make_frame();
            send_frame(1, 1, 8);
        end
        wait_obs("rand", 160, 2000);
        rand_ready = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            o = get_obs(i);
            n_checks++;
            if ({o.re, o.im} !== exp_q[i] || o.first !== 1'(i % 8 == 0)
                || o.last !== 1'(i % 8 == 7)) begin
                n_fail++;
                $display("FAIL rand[%0d]: got %h/%h f%b l%b want %h", i,
                         o.re, o.im, o.first, o.last, exp_q[i]);
            end
        end
        n_checks++;
        if (overflow !== 1'b0 || sync_err !== 1'b0 || nr_cnt != 0) begin
            n_fail++;
            $display("FAIL rand_flags: got ovf=%b se=%b drops=%0d want 0/0/0",
                     overflow, sync_err, nr_cnt);
        end
    endtask

    initial begin
        obs_base = 0;
        nr_cnt = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_reset_midframe();
        test_random_ready();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
